// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared widths, depth default and FSM encodings for the data
//               memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    localparam int DMEM_WIDTH      = 32;
    localparam int DMEM_DEPTH_LOG2 = 8;
    localparam int DMEM_CNT_W      = 4;

    localparam logic [1:0] DMEM_IDLE = 2'd0;
    localparam logic [1:0] DMEM_WAIT = 2'd1;
    localparam logic [1:0] DMEM_RESP = 2'd2;

endpackage : dmem_responder_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Word-addressed storage, synchronous write, combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] r_mem [c_DEPTH];

    // No reset: contents survive rst by design.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : CPU data-port responder: accept -> wait states -> one-cycle
//               ready pulse, backed by a word-addressed array.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int WIDTH       = DMEM_WIDTH,
    parameter int DEPTH_LOG2  = DMEM_DEPTH_LOG2,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             ready,
    output logic             busy,
    output logic             err
);

    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_bad_wait
        $error("dmem_responder: WAIT_CYCLES must be within 0..15");
    end
    if ((DEPTH_LOG2 < 1) || (DEPTH_LOG2 >= WIDTH)) begin : g_bad_depth
        $error("dmem_responder: DEPTH_LOG2 must be within 1..WIDTH-1");
    end

    localparam logic [DMEM_CNT_W-1:0] c_WAIT = DMEM_CNT_W'(WAIT_CYCLES);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [DMEM_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]      r_addr;
    logic [WIDTH-1:0]      r_wdata;
    logic                  r_is_wr;
    logic                  r_oor;
    logic                  r_conflict;
    logic [WIDTH-1:0]      r_rdata;

    logic                  w_req;
    logic                  w_accept;
    logic [WIDTH-1:0]      w_op_addr;
    logic                  w_op_wr;
    logic                  w_in_range;
    logic [WIDTH-1:0]      w_arr_rdata;
    logic                  w_we;
    logic                  w_load_rdata;

    assign w_req    = mem_read | mem_write;
    assign w_accept = (r_state == DMEM_IDLE) && w_req;

    // With zero wait states the response is entered straight from IDLE, so
    // the read path must look at the live request rather than the latches.
    assign w_op_addr  = (r_state == DMEM_IDLE) ? addr : r_addr;
    assign w_op_wr    = (r_state == DMEM_IDLE) ? mem_write : r_is_wr;
    assign w_in_range = (w_op_addr[WIDTH-1:DEPTH_LOG2] == '0);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DMEM_IDLE: begin
                if (w_req) begin
                    w_next_state = (WAIT_CYCLES > 0) ? DMEM_WAIT : DMEM_RESP;
                end
            end
            DMEM_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next_state = DMEM_RESP;
                end
            end
            DMEM_RESP: w_next_state = DMEM_IDLE;
            default:   w_next_state = DMEM_IDLE;
        endcase
    end

    assign w_load_rdata = (w_next_state == DMEM_RESP) && (r_state != DMEM_RESP) && !w_op_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= DMEM_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_wr    <= 1'b0;
            r_oor      <= 1'b0;
            r_conflict <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_addr     <= addr;
                r_wdata    <= wdata;
                r_is_wr    <= mem_write;
                r_oor      <= !w_in_range;
                r_conflict <= mem_read & mem_write;
                r_cnt      <= c_WAIT;
            end else if (r_state == DMEM_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_load_rdata) begin
                r_rdata <= w_in_range ? w_arr_rdata : '0;
            end
        end
    end

    // A reset landing on the edge that ends RESP must still drop the store.
    assign w_we = (r_state == DMEM_RESP) && r_is_wr && !r_oor && !rst;

    dmem_array #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_addr[DEPTH_LOG2-1:0]),
        .i_wdata (r_wdata),
        .i_raddr (w_op_addr[DEPTH_LOG2-1:0]),
        .o_rdata (w_arr_rdata)
    );

    assign rdata = r_rdata;
    assign ready = (r_state == DMEM_RESP);
    assign busy  = (r_state != DMEM_IDLE);
    assign err   = (r_state == DMEM_RESP) && (r_oor || r_conflict);

endmodule : dmem_responder
`default_nettype wire
